sync_filter_multi_bit: RTL and testbench

//   Multi-channel single-clock input conditioner for asynchronous level inputs.
//   - Each bit passes through an N_STAGE metastability chain, then a per-bit glitch filter.
//   - Emits filtered levels plus single-cycle rise/fall pulses per bit.
//   - Sits at async input boundaries: status pins, other-domain flags.
//   - No inter-bit coherency guaranteed; each bit is independent.

---
 rtl/sync_filter_multi_bit.sv | 107 ++++++++++
 tb/tb_sync_filter_multi_bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_multi_bit.sv
// Multi-channel input conditioner: N_STAGE synchroniser, per-bit glitch filter, rise/fall pulses.
// Optional sticky edge flags enabled by defining SYNC_FILTER_STICKY_EN.
module sync_filter_multi_bit #(
  parameter int              SIZE          = 1,
  parameter int              N_STAGE       = 2,
  parameter int              FILTER_CYCLES = 4,
  parameter logic [SIZE-1:0] RST_VAL       = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] dout,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall,
  input  logic [SIZE-1:0] clr,
  output logic [SIZE-1:0] rise_seen,
  output logic [SIZE-1:0] fall_seen
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SIZE-1:0] sync_reg [N_STAGE];
  logic [SIZE-1:0] d_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_STAGE; k++) begin
        sync_reg[k] <= RST_VAL;
      end
    end else begin
      sync_reg[0] <= din;
      for (int k = 1; k < N_STAGE; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign d_sync = sync_reg[N_STAGE-1];

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic          dout_reg;
      logic          rise_reg;
      logic          fall_reg;

      // Any sample that agrees with dout restarts the mismatch run.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          dout_reg <= RST_VAL[gi];
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (d_sync[gi] == dout_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            dout_reg <= d_sync[gi];
            rise_reg <= d_sync[gi];
            fall_reg <= ~d_sync[gi];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign dout[gi] = dout_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;

`ifdef SYNC_FILTER_STICKY_EN
      logic rise_seen_reg;
      logic fall_seen_reg;

      // A new edge outranks a simultaneous clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          rise_seen_reg <= 1'b0;
          fall_seen_reg <= 1'b0;
        end else begin
          if (rise_reg)     rise_seen_reg <= 1'b1;
          else if (clr[gi]) rise_seen_reg <= 1'b0;
          if (fall_reg)     fall_seen_reg <= 1'b1;
          else if (clr[gi]) fall_seen_reg <= 1'b0;
        end
      end

      assign rise_seen[gi] = rise_seen_reg;
      assign fall_seen[gi] = fall_seen_reg;
`else
      assign rise_seen[gi] = 1'b0;
      assign fall_seen[gi] = 1'b0;
`endif
    end
  endgenerate

`ifndef SYNC_FILTER_STICKY_EN
  logic unused_clr;
  assign unused_clr = ^clr;
`endif

endmodule

// File: tb/tb_sync_filter_multi_bit.sv
// Scoreboard bench for sync_filter_multi_bit (SIZE=4, N_STAGE=2, FILTER_CYCLES=3).
// Sticky expectations follow SYNC_FILTER_STICKY_EN when it is defined for the build.
module tb_sync_filter_multi_bit;

  localparam int SIZE = 4;
  localparam int NS   = 2;
  localparam int FC   = 3;

  typedef struct packed {
    logic [SIZE-1:0] dout;
    logic [SIZE-1:0] rise;
    logic [SIZE-1:0] fall;
    logic [SIZE-1:0] rs;
    logic [SIZE-1:0] fs;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] din;
  logic [SIZE-1:0] clr;
  logic [SIZE-1:0] dout, rise, fall, rise_seen, fall_seen;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;
  exp_t sb_q[$];

  // reference state
  logic [SIZE-1:0] m_sync [NS];
  int              m_run [SIZE];
  logic [SIZE-1:0] m_dout, m_rise, m_fall, m_rs, m_fs;

  sync_filter_multi_bit #(
    .SIZE(SIZE), .N_STAGE(NS), .FILTER_CYCLES(FC), .RST_VAL(4'h0)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .clr(clr), .rise_seen(rise_seen), .fall_seen(fall_seen)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  // Spec-level model: a mismatch run of FC samples at the synchroniser output flips dout.
  task automatic model_edge();
    exp_t            e;
    logic [SIZE-1:0] d;
    if (rst) begin
      for (int k = 0; k < NS; k++) m_sync[k] = '0;
      for (int i = 0; i < SIZE; i++) m_run[i] = 0;
      m_dout = '0; m_rise = '0; m_fall = '0; m_rs = '0; m_fs = '0;
    end else begin
`ifdef SYNC_FILTER_STICKY_EN
      m_rs = m_rise | (m_rs & ~clr);
      m_fs = m_fall | (m_fs & ~clr);
`else
      m_rs = '0;
      m_fs = '0;
`endif
      d = m_sync[NS-1];
      for (int i = 0; i < SIZE; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (d[i] != m_dout[i]) begin
          m_run[i]++;
          if (m_run[i] == FC) begin
            m_dout[i] = d[i];
            m_rise[i] = d[i];
            m_fall[i] = ~d[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int k = NS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = din;
    end
    e.dout = m_dout; e.rise = m_rise; e.fall = m_fall; e.rs = m_rs; e.fs = m_fs;
    sb_q.push_back(e);
  endtask

  // Inputs are applied at the falling edge; outputs checked 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    n_txn++;
    e = sb_q.pop_front();
    $display("txn %0d rst=%0b din=%h clr=%h dout=%h rise=%h fall=%h rs=%h fs=%h",
             n_txn, rst, din, clr, dout, rise, fall, rise_seen, fall_seen);
    check_val("dout", 32'(dout), 32'(e.dout));
    check_val("rise", 32'(rise), 32'(e.rise));
    check_val("fall", 32'(fall), 32'(e.fall));
    check_val("rise_seen", 32'(rise_seen), 32'(e.rs));
    check_val("fall_seen", 32'(fall_seen), 32'(e.fs));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Counts edges from the first sampling edge until dout[bit] reaches val (bounded).
  task automatic measure(input int bit_i, input logic val, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (dout[bit_i] !== val && n <= 20);
  endtask

  int   lat;
  logic seen_hi;

  initial begin
    rst = 1'b1; din = 4'hF; clr = 4'h0;
    @(negedge clk);

    // 1: reset with inputs high, then full latency and a rise on every bit
    run(3);
    rst = 1'b0;
    measure(0, 1'b1, lat);
    check_val("rst_release_latency", 32'(lat), 32'd5);
    check_val("rst_release_rise", 32'(rise), 32'hF);
    run(2);

    // 2: single-bit latency
    din = 4'h0; run(8);
    din = 4'h1;
    measure(0, 1'b1, lat);
    check_val("latency_bit0", 32'(lat), 32'd5);
    check_val("latency_rise0", 32'(rise), 32'h1);
    run(3);
    din = 4'h0; run(8);

    // 3: short pulse is filtered, FC-long pulse passes
    din = 4'h2; seen_hi = 1'b0;
    step(); seen_hi |= dout[1];
    step(); seen_hi |= dout[1];
    din = 4'h0;
    for (int k = 0; k < 8; k++) begin step(); seen_hi |= dout[1] | rise[1]; end
    check_val("glitch_blocked", 32'(seen_hi), 32'd0);
    din = 4'h2; run(3);
    din = 4'h0; run(10);

    // 4: multi-bit edge together
    din = 4'h5; run(7);
    din = 4'h0; run(7);

    // 5: sticky flags, including clear colliding with a fresh rise
    din = 4'h4; run(7);
    din = 4'h0; run(7);
    din = 4'h4;
    measure(2, 1'b1, lat);
    check_val("sticky_rise_lat", 32'(lat), 32'd5);
    clr = 4'h4; step();
    clr = 4'h0; run(2);
    clr = 4'h4; step();
    clr = 4'h0; run(2);
    din = 4'h0; run(7);

    // 6: reset in the middle of a filter run
    din = 4'h8; run(4);
    rst = 1'b1; step();
    rst = 1'b0;
    measure(3, 1'b1, lat);
    check_val("midfilter_latency", 32'(lat), 32'd5);
    din = 4'h0; run(8);

    // random soak
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) din = 4'($urandom);
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0; clr = 4'h0; run(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
